// File: rtl/cmd_frame_ctrl.sv
// UART command-frame controller: parses RX bytes into RF writes/reads and ALU operations,
// queues responses to the TX FIFO, and reports unknown-command, timeout and overrun errors.
module cmd_frame_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned ALU_FUN    = 4,
    parameter int unsigned OPA_ADDR   = 0,
    parameter int unsigned OPB_ADDR   = 1,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                    i_clk,
    input  logic                    i_arst_n,
    input  logic                    i_rx_d_valid,
    input  logic [DATA_WIDTH-1:0]   i_p_data,
    input  logic                    i_ff_full,
    input  logic                    i_rd_valid,
    input  logic [DATA_WIDTH-1:0]   i_rd_data,
    input  logic                    i_out_valid,
    input  logic [2*DATA_WIDTH-1:0] i_alu_out,
    output logic [ADDR_WIDTH-1:0]   o_address,
    output logic [DATA_WIDTH-1:0]   o_wr_data,
    output logic                    o_wr_en,
    output logic                    o_rd_en,
    output logic [ALU_FUN-1:0]      o_alu_fun,
    output logic                    o_alu_en,
    output logic                    o_clk_en,
    output logic [DATA_WIDTH-1:0]   o_tx_p_data,
    output logic                    o_tx_p_valid,
    output logic                    o_clk_div_en,
    output logic                    o_busy,
    output logic                    o_frame_err,
    output logic [1:0]              o_err_code
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [7:0] CMD_WR      = 8'hAA;
    localparam logic [7:0] CMD_RD      = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    localparam logic [1:0] ERR_UNKNOWN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_OVERRUN = 2'b11;

    typedef enum logic [3:0] {
        StIdle, StWrAddr, StWrData, StRdAddr, StRdWait,
        StAluA, StAluB, StAluFun, StAluWait, StTxSend
    } state_e;

    state_e state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2*DATA_WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic [1:0] tx_cnt_q, tx_cnt_d;

    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [ALU_FUN-1:0]    alu_fun_q, alu_fun_d;
    logic                  alu_en_q, alu_en_d;
    logic                  clk_en_q, clk_en_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_valid_q, tx_valid_d;
    logic                  clk_div_en_q;
    logic                  busy_q, busy_d;
    logic                  frame_err_q, frame_err_d;
    logic [1:0]            err_code_q, err_code_d;

    logic timed;
    logic expire;
    logic progress;

    assign timed  = (state_q != StIdle) && (state_q != StTxSend);
    assign expire = (TIMEOUT != 0) && timed && (tmo_q == TMO_LAST);

    always_comb begin
        state_d     = state_q;
        tx_buf_d    = tx_buf_q;
        tx_cnt_d    = tx_cnt_q;
        address_d   = address_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        alu_fun_d   = alu_fun_q;
        alu_en_d    = 1'b0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        progress    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_rx_d_valid) begin
                    unique case (i_p_data[7:0])
                        CMD_WR:      state_d = StWrAddr;
                        CMD_RD:      state_d = StRdAddr;
                        CMD_ALU_OP:  state_d = StAluA;
                        CMD_ALU_NOP: state_d = StAluFun;
                        default: begin
                            frame_err_d = 1'b1;
                            err_code_d  = ERR_UNKNOWN;
                        end
                    endcase
                end
            end
            StWrAddr: begin
                if (i_rx_d_valid) begin
                    progress  = 1'b1;
                    address_d = i_p_data[ADDR_WIDTH-1:0];
                    state_d   = StWrData;
                end
            end
            StWrData: begin
                if (i_rx_d_valid) begin
                    progress  = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_data_d = i_p_data;
                    state_d   = StIdle;
                end
            end
            StRdAddr: begin
                if (i_rx_d_valid) begin
                    progress  = 1'b1;
                    address_d = i_p_data[ADDR_WIDTH-1:0];
                    rd_en_d   = 1'b1;
                    state_d   = StRdWait;
                end
            end
            StRdWait: begin
                if (i_rx_d_valid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (i_rd_valid) begin
                    progress = 1'b1;
                    tx_buf_d = {{DATA_WIDTH{1'b0}}, i_rd_data};
                    tx_cnt_d = 2'd1;
                    state_d  = StTxSend;
                end
            end
            StAluA, StAluB: begin
                if (i_rx_d_valid) begin
                    progress  = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_data_d = i_p_data;
                    address_d = (state_q == StAluA) ? ADDR_WIDTH'(OPA_ADDR)
                                                    : ADDR_WIDTH'(OPB_ADDR);
                    state_d   = (state_q == StAluA) ? StAluB : StAluFun;
                end
            end
            StAluFun: begin
                if (i_rx_d_valid) begin
                    progress  = 1'b1;
                    alu_fun_d = i_p_data[ALU_FUN-1:0];
                    alu_en_d  = 1'b1;
                    state_d   = StAluWait;
                end
            end
            StAluWait: begin
                if (i_rx_d_valid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (i_out_valid) begin
                    progress = 1'b1;
                    tx_buf_d = i_alu_out;
                    tx_cnt_d = 2'd2;
                    state_d  = StTxSend;
                end
            end
            StTxSend: begin
                if (i_rx_d_valid) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_OVERRUN;
                end
                if (!i_ff_full) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = tx_buf_q[DATA_WIDTH-1:0];
                    tx_buf_d   = tx_buf_q >> DATA_WIDTH;
                    tx_cnt_d   = tx_cnt_q - 2'd1;
                    if (tx_cnt_q <= 2'd1) begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // An event landing in the expiry cycle wins over the abort.
        if (expire && !progress) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
            err_code_d  = ERR_TIMEOUT;
        end

        clk_en_d = (state_d == StAluWait);
        busy_d   = (state_d != StIdle);
        tmo_d    = ((state_d != state_q) || !timed) ? '0 : tmo_q + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q      <= StIdle;
            tmo_q        <= '0;
            tx_buf_q     <= '0;
            tx_cnt_q     <= '0;
            address_q    <= '0;
            wr_data_q    <= '0;
            wr_en_q      <= 1'b0;
            rd_en_q      <= 1'b0;
            alu_fun_q    <= '0;
            alu_en_q     <= 1'b0;
            clk_en_q     <= 1'b0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            clk_div_en_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            err_code_q   <= '0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            tx_buf_q     <= tx_buf_d;
            tx_cnt_q     <= tx_cnt_d;
            address_q    <= address_d;
            wr_data_q    <= wr_data_d;
            wr_en_q      <= wr_en_d;
            rd_en_q      <= rd_en_d;
            alu_fun_q    <= alu_fun_d;
            alu_en_q     <= alu_en_d;
            clk_en_q     <= clk_en_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            clk_div_en_q <= 1'b1;
            busy_q       <= busy_d;
            frame_err_q  <= frame_err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign o_address    = address_q;
    assign o_wr_data    = wr_data_q;
    assign o_wr_en      = wr_en_q;
    assign o_rd_en      = rd_en_q;
    assign o_alu_fun    = alu_fun_q;
    assign o_alu_en     = alu_en_q;
    assign o_clk_en     = clk_en_q;
    assign o_tx_p_data  = tx_data_q;
    assign o_tx_p_valid = tx_valid_q;
    assign o_clk_div_en = clk_div_en_q;
    assign o_busy       = busy_q;
    assign o_frame_err  = frame_err_q;
    assign o_err_code   = err_code_q;

endmodule

// File: doc/cmd_frame_ctrl.md
Name: cmd_frame_ctrl

Overview:
Parametrised single-clock command controller that replaces the fixed 8-bit system controller. It parses UART command frames from the RX data-sync path and drives register-file writes and reads and ALU operations. Responses are queued into the TX FIFO with full-flag backpressure. Over the previous controller it adds an inter-byte/response timeout, error reporting with cause codes, and an overrun indication.

Parameters:
DATA_WIDTH, 8, RF/RX/TX byte width; must be >= 8; command codes are compared on bits [7:0], upper bits ignored.
ADDR_WIDTH, 4, RF address width; the address byte uses bits [ADDR_WIDTH-1:0].
ALU_FUN, 4, ALU function width; the function byte uses bits [ALU_FUN-1:0].
OPA_ADDR, 0, RF address written with operand A.
OPB_ADDR, 1, RF address written with operand B.
TIMEOUT, 255, cycles allowed between frame events before abort; 0 disables the timeout.

Ports:
i_clk  in  1  system clock
i_arst_n  in  1  asynchronous active-low reset
i_rx_d_valid  in  1  one-cycle pulse: i_p_data valid
i_p_data  in  DATA_WIDTH  received byte
i_ff_full  in  1  TX FIFO full
i_rd_valid  in  1  RF read data valid
i_rd_data  in  DATA_WIDTH  RF read data
i_out_valid  in  1  ALU result valid
i_alu_out  in  2*DATA_WIDTH  ALU result
o_address  out  ADDR_WIDTH  RF address
o_wr_data  out  DATA_WIDTH  RF write data
o_wr_en  out  1  RF write strobe
o_rd_en  out  1  RF read strobe
o_alu_fun  out  ALU_FUN  ALU function
o_alu_en  out  1  ALU enable strobe
o_clk_en  out  1  ALU clock-gate enable
o_tx_p_data  out  DATA_WIDTH  TX FIFO write data
o_tx_p_valid  out  1  TX FIFO write strobe
o_clk_div_en  out  1  TX clock divider enable
o_busy  out  1  frame in progress
o_frame_err  out  1  one-cycle error pulse
o_err_code  out  2  last error cause: 01 unknown command, 10 timeout, 11 overrun

Behaviour:
- All outputs are registered. Reset: every output is 0 and the FSM is in IDLE. o_clk_div_en goes to 1 on the first clock after reset release and stays 1.
- Frames are accepted only on i_rx_d_valid:
  - 0xAA: addr, data (RF write)
  - 0xBB: addr (RF read)
  - 0xCC: A, B, fun (ALU with operands)
  - 0xDD: fun (ALU on stored operands)
- FSM states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_SEND.
- IDLE: the command byte selects WR_ADDR, RD_ADDR, ALU_A or ALU_FUN. Any other code pulses o_frame_err with code 01, stays in IDLE and sends no response.
- WR_ADDR: latch the address and go to WR_DATA.
- WR_DATA: the cycle after the data byte, o_wr_en=1 for exactly one cycle with the latched o_address and the byte on o_wr_data. Then IDLE; no response is sent.
- RD_ADDR: the cycle after the byte, o_rd_en=1 for one cycle and o_address=the address. Go to RD_WAIT.
- RD_WAIT: on i_rd_valid, capture i_rd_data as a 1-byte response and go to TX_SEND.
- ALU_A: o_wr_en pulse writing the byte to OPA_ADDR, then ALU_B.
- ALU_B: o_wr_en pulse writing the byte to OPB_ADDR, then ALU_FUN.
- ALU_FUN:
  - The cycle after the byte, o_alu_fun=byte[ALU_FUN-1:0] and o_alu_en=1 for one cycle. Go to ALU_WAIT.
  - o_clk_en rises with o_alu_en and stays high through ALU_WAIT. It falls the cycle after the result is captured.
- ALU_WAIT: on i_out_valid, capture i_alu_out as a 2-byte response, LS byte first, and go to TX_SEND.
- TX_SEND: each queued byte is written with o_tx_p_valid=1 for exactly one cycle, only in a cycle where i_ff_full=0. While full, hold and write nothing. Consecutive bytes may go on consecutive cycles. After the last byte, go to IDLE.
- Timeout:
  - A counter reloads on state entry and on every accepted byte.
  - In WR_*, RD_*, ALU_* states, TIMEOUT cycles with no expected event aborts to IDLE: no RF write, o_clk_en dropped, o_frame_err pulses with code 10.
  - TX_SEND is exempt from the timeout.
  - A byte arriving in the expiry cycle wins: it is accepted and the counter reloads.
- Overrun: an i_rx_d_valid in RD_WAIT, ALU_WAIT or TX_SEND drops the byte and pulses o_frame_err with code 11. The current operation continues.
- Spurious events: i_rd_valid and i_out_valid are ignored outside their wait states.
- o_busy=1 in every state except IDLE.
- o_err_code holds its value until the next error.
- Reset mid-frame: queued bytes are discarded and no strobe is emitted after reset.

Test Plan:
- Write then read: bytes AA,05,3C then BB,05 with the RF model -> o_wr_en pulse with addr 5 / data 0x3C; one o_tx_p_valid with data 0x3C.
- ALU with operands: CC,07,05,00 (add), model result 0x000C -> writes 07@0 and 05@1, o_alu_en with fun 0, TX bytes 0x0C then 0x00, o_clk_en low afterwards.
- Backpressure: DD,02 with result 0x0023 and i_ff_full=1 for 10 cycles -> no TX strobe while full, then 0x23 and 0x00 on consecutive cycles.
- Timeout (TIMEOUT=20): AA,05 then silence -> o_frame_err on cycle 20 with code 10, no o_wr_en, o_busy=0.
- Unknown command and overrun: byte 0x55 -> error code 01; byte during RD_WAIT -> code 11, and the read response still sent.
- Reset asserted mid ALU_WAIT -> all outputs 0 and no later TX strobe.
